fp_div: RTL and testbench

//  Sequential IEEE-754 single-precision divider z = a / b, built alongside fp_mult.

---
 rtl/fp_div.sv | 217 +++++++++++++++++++++
 tb/tb_fp_div.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// Sequential IEEE-754 single-precision divider z = a / b.
// Restoring radix-2^RADIX_LOG2 mantissa division followed by one normalize/round cycle.
module fp_div #(
   parameter int unsigned RADIX_LOG2 = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  rnd,
   output logic        busy,
   output logic        done,
   output logic [31:0] z,
   output logic [7:0]  status
);

   localparam int unsigned N_DIV = 26 / RADIX_LOG2;

   typedef enum logic [1:0] {IDLE, DIV, ROUND} state_t;

   state_t state, state_nxt;

   logic [23:0]        mb_q;
   logic [25:0]        rem_q, quo_q;
   logic signed [9:0]  exp_q;
   logic               sign_q;
   logic [2:0]         rnd_q;
   logic [4:0]         cnt_q;

   logic               special;
   logic [31:0]        sp_z;
   logic [7:0]         sp_status;

   logic [25:0]        step_rem_in, step_quo_in, step_rem, step_quo;
   logic [23:0]        step_div;

   logic [23:0]        mant;
   logic               guard, sticky, up;
   logic [24:0]        mant_sum;
   logic [22:0]        mant_f;
   logic signed [9:0]  e_pre, e_f;
   logic               tiny, huge, inexact;
   logic [31:0]        rnd_z;
   logic [7:0]         rnd_status;

   assign busy = (state != IDLE);

   // Operand classification on the live inputs; only meaningful in IDLE.
   always_comb begin
      logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
      a_zero    = (a[30:23] == 8'h00);
      a_inf     = (a[30:23] == 8'hFF) && (a[22:0] == '0);
      a_nan     = (a[30:23] == 8'hFF) && (a[22:0] != '0);
      b_zero    = (b[30:23] == 8'h00);
      b_inf     = (b[30:23] == 8'hFF) && (b[22:0] == '0);
      b_nan     = (b[30:23] == 8'hFF) && (b[22:0] != '0);
      special   = 1'b1;
      sp_z      = '0;
      sp_status = '0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         sp_z      = 32'h7FC0_0000;
         sp_status = 8'h04;
      end else if (a_inf || b_zero) begin
         sp_z      = {a[31] ^ b[31], 31'h7F80_0000};
         sp_status = 8'h02;
      end else if (a_zero || b_inf) begin
         sp_z      = {a[31] ^ b[31], 31'h0};
         sp_status = 8'h01;
      end else begin
         special   = 1'b0;
      end
   end

   // The first quotient step runs on the raw operands during the capture
   // edge, so DIV needs only N-1 cycles and the overall latency is N+1.
   always_comb begin
      if (state == IDLE) begin
         step_rem_in = {2'b00, 1'b1, a[22:0]};
         step_quo_in = '0;
         step_div    = {1'b1, b[22:0]};
      end else begin
         step_rem_in = rem_q;
         step_quo_in = quo_q;
         step_div    = mb_q;
      end
      step_rem = step_rem_in;
      step_quo = step_quo_in;
      for (int unsigned i = 0; i < RADIX_LOG2; i++) begin
         if (step_rem >= {2'b00, step_div}) begin
            step_rem = step_rem - {2'b00, step_div};
            step_quo = (step_quo << 1) | 26'd1;
         end else begin
            step_quo = step_quo << 1;
         end
         step_rem = step_rem << 1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && !special) state_nxt = DIV;
         DIV:     if (cnt_q == '0) state_nxt = ROUND;
         ROUND:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      if (quo_q[25]) begin
         mant   = quo_q[25:2];
         guard  = quo_q[1];
         sticky = quo_q[0] | (rem_q != '0);
         e_pre  = exp_q;
      end else begin
         mant   = quo_q[24:1];
         guard  = quo_q[0];
         sticky = (rem_q != '0);
         e_pre  = exp_q - 10'sd1;
      end
      case (rnd_q)
         3'b001:  up = 1'b0;
         3'b010:  up = ~sign_q & (guard | sticky);
         3'b011:  up = sign_q & (guard | sticky);
         3'b100:  up = guard;
         3'b101:  up = guard | sticky;
         default: up = guard & (sticky | mant[0]);
      endcase
      mant_sum = {1'b0, mant} + {24'd0, up};
      if (mant_sum[24]) begin
         mant_f = mant_sum[23:1];
         e_f    = e_pre + 10'sd1;
      end else begin
         mant_f = mant_sum[22:0];
         e_f    = e_pre;
      end
      tiny    = 1'b0;
      huge    = 1'b0;
      inexact = guard | sticky;
      rnd_z   = {sign_q, e_f[7:0], mant_f};
      if (e_f > 10'sd254) begin
         huge    = 1'b1;
         inexact = 1'b1;
         case (rnd_q)
            3'b001:  rnd_z = {sign_q, 31'h7F7F_FFFF};
            3'b010:  rnd_z = sign_q ? 32'hFF7F_FFFF : 32'h7F80_0000;
            3'b011:  rnd_z = sign_q ? 32'hFF80_0000 : 32'h7F7F_FFFF;
            default: rnd_z = {sign_q, 31'h7F80_0000};
         endcase
      end else if (e_f < 10'sd1) begin
         tiny    = 1'b1;
         inexact = 1'b1;
         case (rnd_q)
            3'b101:  rnd_z = {sign_q, 31'h0080_0000};
            3'b010:  rnd_z = sign_q ? 32'h8000_0000 : 32'h0080_0000;
            3'b011:  rnd_z = sign_q ? 32'h8080_0000 : 32'h0000_0000;
            default: rnd_z = {sign_q, 31'h0};
         endcase
      end
      rnd_status = {2'b00, inexact, huge, tiny, 1'b0,
                    rnd_z[30:0] == 31'h7F80_0000, rnd_z[30:0] == 31'h0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         z      <= '0;
         status <= '0;
         done   <= 1'b0;
         mb_q   <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         exp_q  <= '0;
         sign_q <= 1'b0;
         rnd_q  <= '0;
         cnt_q  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (special) begin
                     z      <= sp_z;
                     status <= sp_status;
                     done   <= 1'b1;
                  end else begin
                     mb_q   <= {1'b1, b[22:0]};
                     rem_q  <= step_rem;
                     quo_q  <= step_quo;
                     exp_q  <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
                     sign_q <= a[31] ^ b[31];
                     rnd_q  <= (rnd[2:1] == 2'b11) ? 3'b000 : rnd;
                     cnt_q  <= 5'(N_DIV - 2);
                  end
               end
            end
            DIV: begin
               rem_q <= step_rem;
               quo_q <= step_quo;
               if (cnt_q != '0) cnt_q <= cnt_q - 5'd1;
            end
            ROUND: begin
               z      <= rnd_z;
               status <= rnd_status;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed vectors with literal expectations
// plus an arithmetic reference model checked on every done pulse.
module tb_fp_div;

   localparam int unsigned RADIX_LOG2 = 1;
   localparam int          NORM_LAT   = 26 / RADIX_LOG2 + 1;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] a, b;
   logic [2:0]  rnd;
   logic        busy, done;
   logic [31:0] z;
   logic [7:0]  status;

   int checks   = 0;
   int failures = 0;
   logic [39:0] exp_q[$];

   fp_div #(.RADIX_LOG2(RADIX_LOG2)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .rnd(rnd),
      .busy(busy), .done(done), .z(z), .status(status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: exact integer quotient of the 24-bit mantissas scaled by 2^25.
   function automatic logic [39:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] m_in);
      int ex, ey, e, m;
      longint unsigned mx, my, num, q, r, mant;
      bit neg, g, s, up, xz, yz, xi, yi, xn, yn;
      logic [31:0] res;
      logic [7:0]  st;
      ex  = int'(x[30:23]);
      ey  = int'(y[30:23]);
      neg = x[31] ^ y[31];
      m   = (m_in > 3'd5) ? 0 : int'(m_in);
      xz  = (ex == 0);
      yz  = (ey == 0);
      xi  = (ex == 255) && (x[22:0] == 0);
      yi  = (ey == 255) && (y[22:0] == 0);
      xn  = (ex == 255) && (x[22:0] != 0);
      yn  = (ey == 255) && (y[22:0] != 0);
      if (xn || yn || (xz && yz) || (xi && yi)) return {8'h04, 32'h7FC00000};
      if (xi || yz) return {8'h02, neg, 31'h7F800000};
      if (xz || yi) return {8'h01, neg, 31'h0};
      mx  = 64'(x[22:0]) + 64'h800000;
      my  = 64'(y[22:0]) + 64'h800000;
      num = mx << 25;
      q   = num / my;
      r   = num % my;
      e   = ex - ey + 127;
      if (q >= 64'd33554432) begin
         mant = q >> 2;
         g    = q[1];
         s    = q[0] || (r != 0);
      end else begin
         mant = q >> 1;
         g    = q[0];
         s    = (r != 0);
         e    = e - 1;
      end
      case (m)
         0:       up = g && (s || mant[0]);
         1:       up = 1'b0;
         2:       up = !neg && (g || s);
         3:       up = neg && (g || s);
         4:       up = g;
         default: up = g || s;
      endcase
      mant = mant + 64'(up);
      if (mant == 64'd16777216) begin
         mant = 64'd8388608;
         e    = e + 1;
      end
      st    = '0;
      st[5] = g || s;
      if (e > 254) begin
         st[4] = 1'b1;
         st[5] = 1'b1;
         if (m == 1)      res = {neg, 31'h7F7FFFFF};
         else if (m == 2) res = neg ? 32'hFF7FFFFF : 32'h7F800000;
         else if (m == 3) res = neg ? 32'hFF800000 : 32'h7F7FFFFF;
         else             res = {neg, 31'h7F800000};
      end else if (e < 1) begin
         st[3] = 1'b1;
         st[5] = 1'b1;
         if (m == 5)      res = {neg, 31'h00800000};
         else if (m == 2) res = neg ? 32'h80000000 : 32'h00800000;
         else if (m == 3) res = neg ? 32'h80800000 : 32'h00000000;
         else             res = {neg, 31'h0};
      end else begin
         res = {neg, 8'(e), mant[22:0]};
      end
      st[0] = (res[30:0] == 31'h0);
      st[1] = (res[30:0] == 31'h7F800000);
      return {st, res};
   endfunction

   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0 z=%h", z);
         end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            chk("model_z", z, e[31:0]);
            chk("model_status", 32'(status), 32'(e[39:32]));
         end
      end
   end

   // Called between edges; when the previous op just finished this starts in its done cycle.
   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                         input int want_lat, input bit lit, input logic [31:0] want_z,
                         input logic [7:0] want_st, input bit poke);
      int lat;
      a = x; b = y; rnd = m; start = 1'b1;
      exp_q.push_back(model(x, y, m));
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 1;
      while (!done && lat < 200) begin
         if (poke && lat == 5) begin
            a = 32'h0; b = 32'h0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
         if (poke && lat == 6) chk("busy_after_ignored_start", 32'(busy), 32'd1);
      end
      start = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=%0d required=%0d", lat, want_lat);
         exp_q.delete();
      end else begin
         if (want_lat > 0) chk("latency", 32'(lat), 32'(want_lat));
         if (lit) begin
            chk("literal_z", z, want_z);
            chk("literal_status", 32'(status), 32'(want_st));
         end
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; rnd = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy",   32'(busy),   32'd0);
      chk("reset_done",   32'(done),   32'd0);
      chk("reset_z",      z,           32'd0);
      chk("reset_status", 32'(status), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(32'h40C00000, 32'h40000000, 3'b000, NORM_LAT, 1, 32'h40400000, 8'h00, 0);
      run_op(32'h3F800000, 32'h40400000, 3'b000, NORM_LAT, 1, 32'h3EAAAAAB, 8'h20, 0);
      run_op(32'h3F800000, 32'h40400000, 3'b001, NORM_LAT, 1, 32'h3EAAAAAA, 8'h20, 0);
      run_op(32'h00000000, 32'h00000000, 3'b000, 1,        1, 32'h7FC00000, 8'h04, 0);
      run_op(32'h3F800000, 32'h00000000, 3'b000, 1,        1, 32'h7F800000, 8'h02, 0);
      run_op(32'h7F000000, 32'h3E800000, 3'b000, NORM_LAT, 1, 32'h7F800000, 8'h32, 0);
      run_op(32'h7F000000, 32'h3E800000, 3'b001, NORM_LAT, 1, 32'h7F7FFFFF, 8'h30, 0);
      run_op(32'h00800000, 32'h40000000, 3'b000, NORM_LAT, 1, 32'h00000000, 8'h29, 0);
      run_op(32'h00800000, 32'h40000000, 3'b010, NORM_LAT, 1, 32'h00800000, 8'h28, 0);
      run_op(32'h00800000, 32'h40000000, 3'b101, NORM_LAT, 1, 32'h00800000, 8'h28, 0);
      run_op(32'hBF800000, 32'h40400000, 3'b010, NORM_LAT, 1, 32'hBEAAAAAA, 8'h20, 0);
      run_op(32'hBF800000, 32'h40400000, 3'b011, NORM_LAT, 1, 32'hBEAAAAAB, 8'h20, 0);
      run_op(32'hFF000000, 32'h3E800000, 3'b010, NORM_LAT, 1, 32'hFF7FFFFF, 8'h30, 0);
      run_op(32'hFF000000, 32'h3E800000, 3'b011, NORM_LAT, 1, 32'hFF800000, 8'h32, 0);
      run_op(32'h80800000, 32'h40000000, 3'b011, NORM_LAT, 1, 32'h80800000, 8'h28, 0);
      run_op(32'h7F800000, 32'hC0000000, 3'b000, 1,        1, 32'hFF800000, 8'h02, 0);
      run_op(32'h3F800000, 32'hFF800000, 3'b000, 1,        1, 32'h80000000, 8'h01, 0);
      run_op(32'h7FC00001, 32'h3F800000, 3'b000, 1,        1, 32'h7FC00000, 8'h04, 0);
      run_op(32'h00000001, 32'h3F800000, 3'b000, 1,        1, 32'h00000000, 8'h01, 0);
      run_op(32'h7F800000, 32'h7F800000, 3'b000, 1,        1, 32'h7FC00000, 8'h04, 0);
      run_op(32'hBF800000, 32'h40400000, 3'b100, NORM_LAT, 0, 32'h0, 8'h0, 0);
      run_op(32'hBF800000, 32'h40400000, 3'b101, NORM_LAT, 0, 32'h0, 8'h0, 0);
      run_op(32'hBF800000, 32'h40400000, 3'b110, NORM_LAT, 0, 32'h0, 8'h0, 0);
      run_op(32'h3F800000, 32'h40400000, 3'b111, NORM_LAT, 0, 32'h0, 8'h0, 0);
      run_op(32'h40490FDB, 32'h402DF854, 3'b000, NORM_LAT, 0, 32'h0, 8'h0, 0);
      run_op(32'h3F7FFFFF, 32'h3F800001, 3'b101, NORM_LAT, 0, 32'h0, 8'h0, 0);
      run_op(32'h3F800000, 32'h3F7FFFFF, 3'b000, NORM_LAT, 0, 32'h0, 8'h0, 0);
      run_op(32'h7F7FFFFF, 32'h3F7FFFFF, 3'b000, NORM_LAT, 0, 32'h0, 8'h0, 0);
      run_op(32'h00800000, 32'h3F800001, 3'b011, NORM_LAT, 0, 32'h0, 8'h0, 0);
      run_op(32'hC1200000, 32'h40E00000, 3'b010, NORM_LAT, 0, 32'h0, 8'h0, 0);
      // start while busy must be ignored; the result must still be 6/2
      run_op(32'h40C00000, 32'h40000000, 3'b000, NORM_LAT, 1, 32'h40400000, 8'h00, 1);

      // reset mid-operation, with start asserted in the reset cycle
      a = 32'h40C00000; b = 32'h40000000; rnd = 3'b000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      chk("busy_before_abort", 32'(busy), 32'd1);
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      chk("abort_busy",   32'(busy),   32'd0);
      chk("abort_done",   32'(done),   32'd0);
      chk("abort_z",      z,           32'd0);
      chk("abort_status", 32'(status), 32'd0);
      pulses = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'd0);

      run_op(32'h40C00000, 32'h40000000, 3'b000, NORM_LAT, 1, 32'h40400000, 8'h00, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
